// File: rtl/guitar_input_ctrl_pkg.sv
// Shared defaults and encodings for the guitar controller input front end.
package guitar_input_ctrl_pkg;
  localparam int DEF_NUM_PLAYERS    = 2;
  localparam int DEF_BTN_PER_PLAYER = 3;
  localparam int DEF_TICK_DIV       = 50000;
  localparam int DEF_DEBOUNCE_TICKS = 8;

  // STRUM_MODE encodings
  localparam int STRUM_ANY   = 0;
  localparam int STRUM_GATED = 1;

  // Counter width that stays >= 1 even for a modulus of 1
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/guitar_input_ctrl_debounce.sv
// One input channel: 2-FF synchroniser on the inverted pin, tick-paced debounce, edge pulses.
module guitar_input_ctrl_debounce
  import guitar_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clock,
  input  logic resetn,
  input  logic tick,
  input  logic raw_n,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_w(DEBOUNCE_TICKS);

  logic [1:0]    sync;
  logic          d, d_q;
  logic [CW-1:0] c;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      d    <= 1'b0;
      d_q  <= 1'b0;
      c    <= '0;
    end else begin
      sync <= {sync[0], ~raw_n};
      d_q  <= d;
      // Any tick that agrees with d wipes the count, so bounces earn no credit
      if (tick) begin
        if (sync[1] == d) begin
          c <= '0;
        end else if (c == CW'(DEBOUNCE_TICKS - 1)) begin
          d <= sync[1];
          c <= '0;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

  assign level = d;
  assign rise  = d & ~d_q;
  assign fall  = ~d & d_q;
endmodule

// File: rtl/guitar_input_ctrl.sv
// Guitar controller front end: shared debounce prescaler, per-channel debouncers,
// per-player chord capture with sticky event flags cleared by the processor.
module guitar_input_ctrl
  import guitar_input_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS    = DEF_NUM_PLAYERS,
  parameter int BTN_PER_PLAYER = DEF_BTN_PER_PLAYER,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int STRUM_MODE     = STRUM_GATED
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0] btn_n,
  input  logic [NUM_PLAYERS-1:0]                strum_n,
  output logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0] held,
  output logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0] press_pulse,
  output logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0] release_pulse,
  output logic [NUM_PLAYERS-1:0]                note_valid,
  output logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0] note_chord,
  output logic [NUM_PLAYERS-1:0]                evt_pending,
  input  logic [NUM_PLAYERS-1:0]                evt_ack,
  output logic                                  tick
);
  localparam int NCH = NUM_PLAYERS * BTN_PER_PLAYER;
  localparam int BPP = BTN_PER_PLAYER;
  localparam int PW  = cnt_w(TICK_DIV);

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= tick ? '0 : cnt + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_btn
    guitar_input_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clock (clock),
      .resetn(resetn),
      .tick  (tick),
      .raw_n (btn_n[i]),
      .level (held[i]),
      .rise  (press_pulse[i]),
      .fall  (release_pulse[i])
    );
  end

  logic [NUM_PLAYERS-1:0] strum_lvl, strum_rise, strum_fall;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_strum
    guitar_input_ctrl_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clock (clock),
      .resetn(resetn),
      .tick  (tick),
      .raw_n (strum_n[p]),
      .level (strum_lvl[p]),
      .rise  (strum_rise[p]),
      .fall  (strum_fall[p])
    );
  end

  // Strum level/release (and strum_rise in button mode) have no consumer here
  logic strum_unused;
  assign strum_unused = ^{strum_lvl, strum_fall, strum_rise};

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ply
    logic [BPP-1:0] held_s, press_s, chord_r;
    logic           nv_r, pend_r;

    assign held_s  = held[p*BPP +: BPP];
    assign press_s = press_pulse[p*BPP +: BPP];

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        chord_r <= '0;
        nv_r    <= 1'b0;
        pend_r  <= 1'b0;
      end else begin
        nv_r <= 1'b0;
        if (STRUM_MODE == STRUM_GATED) begin
          // An open strum still overwrites the chord, but raises no event
          if (strum_rise[p]) begin
            chord_r <= held_s;
            nv_r    <= |held_s;
          end
        end else if (|press_s) begin
          chord_r <= held_s | press_s;
          nv_r    <= 1'b1;
        end
        // New event beats a same-cycle ack so no event is silently lost
        pend_r <= nv_r | (pend_r & ~evt_ack[p]);
      end
    end

    assign note_chord[p*BPP +: BPP] = chord_r;
    assign note_valid[p]            = nv_r;
    assign evt_pending[p]           = pend_r;
  end
endmodule

// File: tb/tb_guitar_input_ctrl.sv
// Directed bench: strum-gated instance (TICK_DIV=4) plus button-mode instance (TICK_DIV=1).
module tb_guitar_input_ctrl;
  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] btn_n, held, press, rel, chord;
  logic [1:0] strum_n, nv, pend, ack;
  logic       tick_a;
  logic [5:0] btn_b, held_b, press_b, rel_b, chord_b;
  logic [1:0] strum_b, nv_b, pend_b, ack_b;
  logic       tick_b;

  int total = 0;
  int bad   = 0;
  int press0_n = 0, rel0_n = 0, nv0_n = 0, nv1_n = 0;
  int snap_a, snap_b;

  always #5 clock = ~clock;

  guitar_input_ctrl #(.NUM_PLAYERS(2), .BTN_PER_PLAYER(3), .TICK_DIV(4),
                      .DEBOUNCE_TICKS(3), .STRUM_MODE(1)) u_dut (
    .clock(clock), .resetn(resetn), .btn_n(btn_n), .strum_n(strum_n),
    .held(held), .press_pulse(press), .release_pulse(rel), .note_valid(nv),
    .note_chord(chord), .evt_pending(pend), .evt_ack(ack), .tick(tick_a)
  );

  guitar_input_ctrl #(.NUM_PLAYERS(2), .BTN_PER_PLAYER(3), .TICK_DIV(1),
                      .DEBOUNCE_TICKS(3), .STRUM_MODE(0)) u_dut_b (
    .clock(clock), .resetn(resetn), .btn_n(btn_b), .strum_n(strum_b),
    .held(held_b), .press_pulse(press_b), .release_pulse(rel_b), .note_valid(nv_b),
    .note_chord(chord_b), .evt_pending(pend_b), .evt_ack(ack_b), .tick(tick_b)
  );

  always @(negedge clock) begin
    if (press[0]) press0_n++;
    if (rel[0])   rel0_n++;
    if (nv[0])    nv0_n++;
    if (nv[1])    nv1_n++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_held(input logic [5:0] mask, input logic [5:0] val);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if ((held & mask) == val) break;
    end
  endtask

  task automatic wait_nv(input int p);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (nv[p]) break;
    end
  endtask

  initial begin
    logic early;
    resetn = 1'b0; btn_n = '1; strum_n = '1; ack = '0;
    btn_b  = '1;  strum_b = '1; ack_b = '0;
    cyc(3);
    chk("rst_held", held, 0);
    chk("rst_nv", nv, 0);
    chk("rst_chord", chord, 0);
    chk("rst_pend", pend, 0);
    chk("rst_tick_div4", tick_a, 0);
    chk("rst_tick_div1", tick_b, 1);

    // Reset behaviour: hold everything, then reset mid-run and re-debounce
    resetn = 1'b1; btn_n = '0;
    wait_held(6'h3F, 6'h3F);
    chk("hold_all", held, 6'h3F);
    cyc(2);
    resetn = 1'b0;
    #1;
    chk("async_rst_held", held, 0);
    chk("async_rst_press", press, 0);
    cyc(2);
    resetn = 1'b1;
    cyc(11);
    chk("rerelease_before_3_ticks", held, 0);
    cyc(1);
    chk("rerelease_after_3_ticks", held, 6'h3F);
    chk("rerelease_press", press, 6'h3F);
    btn_n = '1;
    wait_held(6'h3F, 6'h00);
    chk("release_all", held, 0);
    cyc(4);

    // Bounce on btn 0: low 2 ticks, high 1 tick, then steady low
    snap_a = press0_n; snap_b = rel0_n;
    btn_n[0] = 1'b0; cyc(8);
    btn_n[0] = 1'b1; cyc(4);
    chk("bounce_not_accepted", held[0], 0);
    btn_n[0] = 1'b0; cyc(30);
    chk("bounce_held", held[0], 1);
    chk("bounce_one_press", press0_n - snap_a, 1);
    chk("bounce_no_release", rel0_n - snap_b, 0);

    // Strum chord on player 0 with buttons 0 and 2
    btn_n[2] = 1'b0;
    wait_held(6'h04, 6'h04);
    cyc(2);
    snap_a = nv0_n;
    strum_n[0] = 1'b0;
    wait_nv(0);
    chk("strum_nv", nv[0], 1);
    chk("strum_chord", chord[2:0], 3'b101);
    cyc(1);
    chk("strum_nv_one_cycle", nv[0], 0);
    chk("strum_pend", pend[0], 1);
    strum_n[0] = 1'b1;
    cyc(30);
    chk("strum_nv_count", nv0_n - snap_a, 1);

    // Open strum on player 1 after a real chord: chord clears, no event
    btn_n[3] = 1'b0;
    wait_held(6'h08, 6'h08);
    cyc(2);
    strum_n[1] = 1'b0;
    wait_nv(1);
    chk("p1_chord", chord[5:3], 3'b001);
    strum_n[1] = 1'b1; btn_n[3] = 1'b1;
    cyc(30);
    chk("p1_released", held[3], 0);
    chk("p1_pend", pend[1], 1);
    snap_a = nv1_n;
    strum_n[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (chord[5:3] == 3'b000) break;
    end
    chk("open_chord", chord[5:3], 0);
    cyc(2);
    chk("open_no_nv", nv1_n - snap_a, 0);
    chk("open_pend_kept", pend[1], 1);
    strum_n[1] = 1'b1;
    cyc(30);

    // Ack in the same cycle as a new event: set wins
    strum_n[0] = 1'b0;
    wait_nv(0);
    chk("race_nv", nv[0], 1);
    ack[0] = 1'b1; cyc(1); ack[0] = 1'b0;
    chk("race_set_wins", pend[0], 1);
    strum_n[0] = 1'b1;
    cyc(2);
    ack[0] = 1'b1; cyc(1); ack[0] = 1'b0;
    chk("lone_ack_clears", pend[0], 0);
    chk("ack_independent", pend[1], 1);
    ack[1] = 1'b1; cyc(1); ack[1] = 1'b0;
    chk("ack_p1_clears", pend[1], 0);

    // Button mode, TICK_DIV=1: event exactly 2+3+1 cycles after the press
    btn_b[4] = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (nv_b != 2'b00) early = 1'b1;
    end
    chk("b_no_early_event", early, 0);
    cyc(1);
    chk("b_nv", nv_b, 2'b10);
    chk("b_chord_p1", chord_b[5:3], 3'b010);
    chk("b_chord_p0", chord_b[2:0], 3'b000);
    cyc(1);
    chk("b_pend", pend_b, 2'b10);
    chk("b_nv_cleared", nv_b, 2'b00);
    chk("b_tick_const", tick_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
